// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined W-bit N:1 selector.
// Every level is a registered 4:1 reduction, so the select width must be even.
package mux_pkg;

    localparam int MAX_SEL_BITS = 8;

    function automatic int level_count(input int sel_bits);
        return sel_bits / 2;
    endfunction

    // Lanes entering level k. Level k hands a quarter of them to level k+1.
    function automatic int lanes_at_level(input int sel_bits, input int k);
        return 1 << (sel_bits - 2 * k);
    endfunction

    function automatic bit sel_bits_legal(input int sel_bits);
        return (sel_bits % 2 == 0) && (sel_bits >= 2) && (sel_bits <= MAX_SEL_BITS);
    endfunction

endpackage

// File: rtl/muxw4_1.sv
// Combinational W-bit 4:1 selector, the building block of every tree level.
module muxw4_1 #(
    parameter int WIDTH = 64
) (
    input  logic [3:0][WIDTH-1:0] lanes,
    input  logic [1:0]            sel,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        y = lanes[sel];
    end

endmodule

// File: rtl/pipelined_mux_tree.sv
// Pipelined W-bit N:1 selector: one registered 4:1 level per select-bit pair,
// with a global enable (stall) and a flush that only kills the valid bits.
module pipelined_mux_tree
    import mux_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int SEL_BITS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [(1 << SEL_BITS)*WIDTH-1:0]  in_data,
    input  logic [SEL_BITS-1:0]               selection,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data
);

    localparam int L = level_count(SEL_BITS);

    if (!sel_bits_legal(SEL_BITS)) begin : g_bad_param
        $error("pipelined_mux_tree: SEL_BITS must be even and within 2..%0d", MAX_SEL_BITS);
    end

    // vld_pipe[0] is the incoming valid; vld_pipe[k+1] belongs to level k.
    logic [L-1:0] vld_q;
    logic [L:0]   vld_pipe;

    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[L];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       vld_q <= '0;
        else if (flush)  vld_q <= '0;
        else if (enable) vld_q <= vld_pipe[L-1:0];
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NI = lanes_at_level(SEL_BITS, k);
        localparam int NO = NI / 4;
        localparam int SI = SEL_BITS - 2 * k;

        logic [NI-1:0][WIDTH-1:0] src_data;
        logic [SI-1:0]            src_sel;
        logic [NO-1:0][WIDTH-1:0] red_data;
        logic [NO-1:0][WIDTH-1:0] data_q;

        if (k == 0) begin : g_src
            assign src_data = in_data;
            assign src_sel  = selection;
        end else begin : g_src
            assign src_data = g_lvl[k-1].data_q;
            assign src_sel  = g_lvl[k-1].g_sel.sel_q;
        end

        // Group j covers lanes 4j..4j+3, so the surviving index is j.
        for (genvar j = 0; j < NO; j++) begin : g_mux
            muxw4_1 #(.WIDTH(WIDTH)) u_mux (
                .lanes (src_data[4*j+3 -: 4]),
                .sel   (src_sel[1:0]),
                .y     (red_data[j])
            );
        end

        // Data loads on every enabled edge, valid or not.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)       data_q <= '0;
            else if (enable) data_q <= red_data;
        end

        // Only the select bits still needed downstream are carried forward.
        if (SI > 2) begin : g_sel
            logic [SI-3:0] sel_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)       sel_q <= '0;
                else if (enable) sel_q <= src_sel[SI-1:2];
            end
        end
    end

    assign out_data = g_lvl[L-1].data_q[0];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Scoreboard bench for pipelined_mux_tree: a SEL_BITS=4 and a SEL_BITS=6 instance
// share clock, reset, enable and flush; expected lanes are queued at acceptance.
module tb_pipelined_mux_tree;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] d;
        int           iss;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset, enable, flush;
    logic              iv4, iv6;
    logic [16*W-1:0]   in4;
    logic [64*W-1:0]   in6;
    logic [3:0]        sel4;
    logic [5:0]        sel6;
    logic              ov4, ov6;
    logic [W-1:0]      od4, od6;

    int  n_chk = 0;
    int  n_err = 0;
    int  en_edges = 0;
    bit  adv = 1'b0;
    bit  fl = 1'b0;
    sb_t q4[$];
    sb_t q6[$];

    always #5 clk = ~clk;

    pipelined_mux_tree #(.WIDTH(W), .SEL_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(iv4), .in_data(in4), .selection(sel4),
        .out_valid(ov4), .out_data(od4)
    );

    pipelined_mux_tree #(.WIDTH(W), .SEL_BITS(6)) u_dut6 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(iv6), .in_data(in6), .selection(sel6),
        .out_valid(ov6), .out_data(od6)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand6();
        for (int i = 0; i < 128; i++) in6[i*32 +: 32] = $urandom;
    endtask

    // Acceptance model: an enabled, unflushed edge with in_valid queues the chosen lane.
    always @(posedge clk) begin
        adv = enable && !reset;
        fl  = flush && !reset;
        if (!reset) begin
            if (flush) begin
                q4.delete();
                q6.delete();
            end else if (enable) begin
                if (iv4) q4.push_back('{in4[sel4*W +: W], en_edges});
                if (iv6) q6.push_back('{in6[sel6*W +: W], en_edges});
            end
            if (enable) en_edges++;
        end
    end

    // An output counts once per enabled edge; the head is due after L enabled edges.
    always @(negedge clk) begin : mon
        bit ev;
        if (adv) begin
            ev = (q4.size() > 0) && (en_edges - q4[0].iss >= 2);
            chk("vld4", W'(ov4), W'(ev));
            if (ev) begin
                chk("dat4", od4, q4[0].d);
                void'(q4.pop_front());
            end
            ev = (q6.size() > 0) && (en_edges - q6[0].iss >= 3);
            chk("vld6", W'(ov6), W'(ev));
            if (ev) begin
                chk("dat6", od6, q6[0].d);
                void'(q6.pop_front());
            end
        end else if (fl) begin
            chk("flush_vld4", W'(ov4), '0);
            chk("flush_vld6", W'(ov6), '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with live-looking inputs
        reset = 1'b1; enable = 1'b1; flush = 1'b0;
        iv4 = 1'b1; iv6 = 1'b1;
        sel4 = 4'($urandom); sel6 = 6'($urandom);
        for (int i = 0; i < 32; i++) in4[i*32 +: 32] = $urandom;
        rand6();
        repeat (3) tick();
        chk("rst_vld4", W'(ov4), '0);
        chk("rst_dat4", od4, '0);
        chk("rst_vld6", W'(ov6), '0);
        chk("rst_dat6", od6, '0);
        reset = 1'b0; iv4 = 1'b0; iv6 = 1'b0;
        tick();

        // Single select: lane i = {16{i}}
        for (int i = 0; i < 16; i++) in4[i*W +: W] = {16{4'(i)}};
        sel4 = 4'hB; iv4 = 1'b1;
        tick();
        chk("single_early", W'(ov4), '0);
        iv4 = 1'b0;
        tick();
        chk("single_vld", W'(ov4), 64'd1);
        chk("single_dat", od4, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        chk("single_after", W'(ov4), '0);

        // Back-to-back 0, 5, 15
        iv4 = 1'b1; sel4 = 4'h0;
        tick();
        sel4 = 4'h5;
        tick();
        chk("b2b_0", od4, 64'h0);
        sel4 = 4'hF;
        tick();
        chk("b2b_5_vld", W'(ov4), 64'd1);
        chk("b2b_5", od4, 64'h5555_5555_5555_5555);
        iv4 = 1'b0;
        tick();
        chk("b2b_f_vld", W'(ov4), 64'd1);
        chk("b2b_f", od4, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // Stall with two in flight; inputs during the stall must be ignored
        iv4 = 1'b1; sel4 = 4'h3;
        tick();
        sel4 = 4'h9;
        tick();
        enable = 1'b0; sel4 = 4'h7;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_vld", W'(ov4), 64'd1);
            chk("stall_dat", od4, 64'h3333_3333_3333_3333);
        end
        iv4 = 1'b0; enable = 1'b1;
        tick();
        chk("resume_dat", od4, 64'h9999_9999_9999_9999);
        tick();
        chk("resume_end", W'(ov4), '0);

        // Flush with enable=0 and transactions in flight in both trees
        rand6();
        iv4 = 1'b1; sel4 = 4'h1; iv6 = 1'b1; sel6 = 6'd17;
        tick();
        sel4 = 4'h2; sel6 = 6'd42;
        tick();
        iv4 = 1'b0; iv6 = 1'b0; enable = 1'b0; flush = 1'b1;
        tick();
        chk("flush_now4", W'(ov4), '0);
        chk("flush_now6", W'(ov6), '0);
        flush = 1'b0; enable = 1'b1;
        repeat (4) tick();

        // Flush wins over an enabled, valid sample
        iv4 = 1'b1; sel4 = 4'hC; flush = 1'b1;
        tick();
        iv4 = 1'b0; flush = 1'b0;
        repeat (3) begin
            tick();
            chk("flush_drop4", W'(ov4), '0);
        end

        // Sweep all 64 selections; async reset pulse mid-sweep, then a clean restart
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 64; s++) begin
                rand6();
                sel6 = 6'(s); iv6 = 1'b1;
                tick();
                if (p == 0 && s == 30) begin
                    chk("pre_rst_vld6", W'(ov6), 64'd1);
                    #2;
                    reset = 1'b1;
                    q4.delete();
                    q6.delete();
                    #1;
                    chk("arst_vld6", W'(ov6), '0);
                    chk("arst_dat6", od6, '0);
                    tick();
                    chk("arst_hold6", W'(ov6), '0);
                    reset = 1'b0;
                    break;
                end
            end
        end
        iv6 = 1'b0;
        repeat (5) tick();

        chk("sb4_empty", W'(q4.size()), '0);
        chk("sb6_empty", W'(q6.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
